// File: rtl/scroll_key_reader.sv
// scroll_key_reader: synchronises and debounces four push-buttons, turns
// confirmed presses (and auto-repeats on the speed keys) into one-cycle
// events, and holds the scroll control registers for the LED scroller.
//
// Key FSM states (one FSM per key)
//   state        | meaning
//   IDLE         | key released and stable, counter held at 0
//   PRESS_WAIT   | synchronised input high, counting towards a confirmed press
//   HELD         | press confirmed, key down
//   RELEASE_WAIT | input low while held, counting towards a confirmed release
//
// CNT_DB must be at least 2. The first sample that sees the key high moves
// the FSM to PRESS_WAIT with the counter still at 0. The accepting sample is
// therefore the one where the counter would reach CNT_DB-1, which gives
// CNT_DB consecutive stable samples in total.
module scroll_key_reader #(
   parameter logic [26:0] CNT_DB   = 27'd1_000_000,
   parameter logic [26:0] CNT_HOLD = 27'd50_000_000,
   parameter logic [26:0] CNT_REP  = 27'd10_000_000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [3:0] btn,
   output logic       dir,
   output logic [2:0] speed,
   output logic       pause,
   output logic       key_evt,
   output logic [1:0] key_code
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_state_e;

   localparam logic [26:0] DB_LAST     = CNT_DB - 27'd2;
   localparam logic [26:0] HOLD_LAST   = CNT_HOLD - 27'd1;
   // Reloading to CNT_HOLD-CNT_REP makes later repeats reuse the same
   // terminal compare, CNT_REP cycles apart.
   localparam logic [26:0] HOLD_RELOAD = CNT_HOLD - CNT_REP;

   logic [3:0]  sync1_q, sync2_q;
   key_state_e  state_q [4];
   key_state_e  state_d [4];
   logic [26:0] cnt_q [4];
   logic [26:0] cnt_d [4];
   logic [26:0] hold_q [4];
   logic [26:0] hold_d [4];
   logic [3:0]  accept;

   logic       dir_q, dir_d;
   logic [2:0] speed_q, speed_d;
   logic       pause_q, pause_d;
   logic       evt_q, evt_d;
   logic [1:0] code_q, code_d;

   // Per-key debounce FSM, hold/repeat timer and acceptance strobes.
   always_comb begin
      accept = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         state_d[k] = state_q[k];
         cnt_d[k]   = cnt_q[k];
         hold_d[k]  = 27'd0;
         case (state_q[k])
            IDLE: begin
               cnt_d[k] = 27'd0;
               if (sync2_q[k]) state_d[k] = PRESS_WAIT;
            end
            PRESS_WAIT: begin
               if (!sync2_q[k]) begin
                  state_d[k] = IDLE;
                  cnt_d[k]   = 27'd0;
               end else if (cnt_q[k] == DB_LAST) begin
                  state_d[k] = HELD;
                  cnt_d[k]   = 27'd0;
                  accept[k]  = 1'b1;
               end else begin
                  cnt_d[k] = cnt_q[k] + 27'd1;
               end
            end
            HELD: begin
               cnt_d[k] = 27'd0;
               if (!sync2_q[k]) state_d[k] = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
               if (sync2_q[k]) begin
                  state_d[k] = HELD;
                  cnt_d[k]   = 27'd0;
               end else if (cnt_q[k] == DB_LAST) begin
                  state_d[k] = IDLE;
                  cnt_d[k]   = 27'd0;
               end else begin
                  cnt_d[k] = cnt_q[k] + 27'd1;
               end
            end
            default: begin
               state_d[k] = IDLE;
               cnt_d[k]   = 27'd0;
            end
         endcase
         // Only the speed keys auto-repeat; the timer keeps running through
         // a release bounce so a short dropout does not restart the hold.
         if ((k == 1 || k == 2) &&
             (state_q[k] == HELD || state_q[k] == RELEASE_WAIT)) begin
            if (hold_q[k] == HOLD_LAST) begin
               hold_d[k] = HOLD_RELOAD;
               accept[k] = 1'b1;
            end else begin
               hold_d[k] = hold_q[k] + 27'd1;
            end
         end
      end
   end

   // Control register updates and event/key-code generation.
   always_comb begin
      dir_d   = dir_q ^ accept[0];
      pause_d = pause_q ^ accept[3];
      speed_d = speed_q;
      if (accept[1] && !accept[2] && speed_q != 3'd7)
         speed_d = speed_q + 3'd1;
      else if (accept[2] && !accept[1] && speed_q != 3'd0)
         speed_d = speed_q - 3'd1;
      evt_d  = |accept;
      code_d = code_q;
      if (accept[0])      code_d = 2'd0;
      else if (accept[1]) code_d = 2'd1;
      else if (accept[2]) code_d = 2'd2;
      else if (accept[3]) code_d = 2'd3;
   end

   // State registers with synchronous active-low reset taking priority.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync1_q <= 4'b0000;
         sync2_q <= 4'b0000;
         for (int k = 0; k < 4; k++) begin
            state_q[k] <= IDLE;
            cnt_q[k]   <= 27'd0;
            hold_q[k]  <= 27'd0;
         end
         dir_q   <= 1'b0;
         speed_q <= 3'd3;
         pause_q <= 1'b0;
         evt_q   <= 1'b0;
         code_q  <= 2'd0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         for (int k = 0; k < 4; k++) begin
            state_q[k] <= state_d[k];
            cnt_q[k]   <= cnt_d[k];
            hold_q[k]  <= hold_d[k];
         end
         dir_q   <= dir_d;
         speed_q <= speed_d;
         pause_q <= pause_d;
         evt_q   <= evt_d;
         code_q  <= code_d;
      end
   end

   assign dir      = dir_q;
   assign speed    = speed_q;
   assign pause    = pause_q;
   assign key_evt  = evt_q;
   assign key_code = code_q;

endmodule
